// File: rtl/multicycle_core_sequencer.sv
// multicycle_core_sequencer: multi-cycle fetch/decode/execute/writeback control FSM owning the PC
module multicycle_core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int IMEM_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  read_reg1,
  output logic [4:0]  read_reg2,
  output logic [4:0]  write_reg,
  output logic [5:0]  alu_control,
  output logic [31:0] imm_val,
  output logic [3:0]  sh_amt,
  output logic [31:0] imm_val_lui,
  output logic        lb,
  output logic        sw,
  output logic        lui_control,
  output logic        beq_control,
  output logic        bneq_control,
  output logic        blt_control,
  output logic        bgeq_control,
  input  logic        beq,
  input  logic        bneq,
  input  logic        bge,
  input  logic        blt,
  output logic [31:0] pc,
  output logic        halt,
  output logic        fault
);
  localparam int CW = $clog2(IMEM_TIMEOUT + 1);
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, WRITEBACK, HALT} state_t;
  state_t state, next_state;
  logic [31:0] ir;
  logic [CW-1:0] cnt;
  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic [5:0] alu_dec;
  logic legal, is_lb, is_sw, is_lui, is_br, is_sys, taken, timeout, ex;
  logic [31:0] i_imm, s_imm, b_imm;
  assign opcode = ir[6:0];
  assign f3 = ir[14:12];
  assign f7 = ir[31:25];
  assign is_lb = opcode == 7'b0000011;
  assign is_sw = opcode == 7'b0100011;
  assign is_lui = opcode == 7'b0110111;
  assign is_br = opcode == 7'b1100011;
  assign is_sys = opcode == 7'b1110011;
  assign i_imm = {{20{ir[31]}}, ir[31:20]};
  assign s_imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign b_imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign taken = beq | bneq | bge | blt;
  // a fetch accepted on the terminal-count cycle wins over the timeout
  assign timeout = state == FETCH && !imem_ready && cnt == CW'(IMEM_TIMEOUT - 1);
  assign ex = state == EXECUTE;
  // instruction decode: ALU opcode and legality; unsupported funct codes are treated as illegal
  always_comb begin
    alu_dec = 6'd0;
    legal = 1'b0;
    case (opcode)
      7'b0110011: begin
        legal = 1'b1;
        case ({f7, f3})
          {7'h00, 3'd0}: alu_dec = 6'd1;
          {7'h20, 3'd0}: alu_dec = 6'd2;
          {7'h00, 3'd7}: alu_dec = 6'd3;
          {7'h00, 3'd6}: alu_dec = 6'd4;
          {7'h00, 3'd4}: alu_dec = 6'd5;
          {7'h00, 3'd1}: alu_dec = 6'd6;
          {7'h00, 3'd5}: alu_dec = 6'd7;
          {7'h00, 3'd2}: alu_dec = 6'd8;
          default: legal = 1'b0;
        endcase
      end
      7'b0010011: begin
        legal = 1'b1;
        case (f3)
          3'd0: alu_dec = 6'd11;
          3'd7: alu_dec = 6'd12;
          3'd6: alu_dec = 6'd13;
          3'd4: alu_dec = 6'd14;
          3'd1: begin alu_dec = 6'd15; legal = f7 == 7'h00; end
          3'd5: begin alu_dec = 6'd16; legal = f7 == 7'h00; end
          default: legal = 1'b0;
        endcase
      end
      7'b0000011: legal = f3 == 3'b000;
      7'b0100011: legal = f3 == 3'b010;
      7'b0110111: legal = 1'b1;
      7'b1100011: begin
        legal = 1'b1;
        case (f3)
          3'd0: alu_dec = 6'd20;
          3'd1: alu_dec = 6'd21;
          3'd4: alu_dec = 6'd22;
          3'd5: alu_dec = 6'd23;
          default: legal = 1'b0;
        endcase
      end
      7'b1110011: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else state <= next_state;
  end
  // next-state: branches and stores skip writeback, system/illegal instructions stop the core
  always_comb begin
    next_state = state;
    case (state)
      FETCH: next_state = imem_ready ? DECODE : (timeout ? HALT : FETCH);
      DECODE: next_state = (is_sys || !legal) ? HALT : EXECUTE;
      EXECUTE: next_state = (is_br || is_sw) ? FETCH : WRITEBACK;
      WRITEBACK: next_state = FETCH;
      default: next_state = HALT;
    endcase
  end
  // PC, instruction register, fetch-wait counter and sticky fault
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
      ir <= 32'h0000_0013;
      cnt <= '0;
      fault <= 1'b0;
    end else begin
      cnt <= (state == FETCH && !imem_ready) ? cnt + CW'(1) : '0;
      if (state == FETCH && imem_ready) ir <= imem_rdata;
      if (ex && is_br) pc <= taken ? pc + b_imm : pc + 32'd4;
      else if ((ex && is_sw) || state == WRITEBACK) pc <= pc + 32'd4;
      if (timeout || (state == DECODE && !legal)) fault <= 1'b1;
    end
  end
  // outputs: selects follow IR, strobes pulse only in EXECUTE, rd only in WRITEBACK
  always_comb begin
    imem_req = state == FETCH;
    imem_addr = pc;
    halt = state == HALT;
    read_reg1 = ir[19:15];
    read_reg2 = ir[24:20];
    write_reg = state == WRITEBACK ? ir[11:7] : 5'd0;
    alu_control = (state == DECODE || ex || state == WRITEBACK) ? alu_dec : 6'd0;
    imm_val = is_sw ? s_imm : (is_br ? b_imm : i_imm);
    sh_amt = ir[23:20];
    imm_val_lui = {ir[31:12], 12'b0};
    lb = ex && is_lb;
    sw = ex && is_sw;
    lui_control = ex && is_lui;
    beq_control = ex && is_br && f3 == 3'd0;
    bneq_control = ex && is_br && f3 == 3'd1;
    blt_control = ex && is_br && f3 == 3'd4;
    bgeq_control = ex && is_br && f3 == 3'd5;
  end
endmodule

// File: tb/tb_multicycle_core_sequencer.sv
// tb_multicycle_core_sequencer: randomized instruction stream checked against an instruction-level model
module tb_multicycle_core_sequencer;
  logic clk = 0, rst = 1;
  logic imem_req, imem_ready = 0;
  logic [31:0] imem_addr, imem_rdata = 0;
  logic [4:0] read_reg1, read_reg2, write_reg;
  logic [5:0] alu_control;
  logic [31:0] imm_val, imm_val_lui, pc;
  logic [3:0] sh_amt;
  logic lb, sw, lui_control, beq_control, bneq_control, blt_control, bgeq_control;
  logic beq = 0, bneq = 0, bge = 0, blt = 0;
  logic halt, fault;
  int checks = 0, errors = 0;
  logic [31:0] mpc;
  logic [31:0] e_ins, e_imm, e_lui, e_off;
  logic [5:0] e_alu;
  logic [6:0] e_stb;
  logic [4:0] e_rd, e_rs1, e_rs2;
  logic [3:0] e_sh, e_fl;
  bit e_wb, e_br, e_halt, e_fault, e_chk_alu, e_chk_imm, e_chk_rs1, e_chk_rs2, e_chk_sh, e_chk_lui;
  int e_lat;
  logic [2:0] r_f3 [8] = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd4, 3'd1, 3'd5, 3'd2};
  logic [2:0] i_f3 [6] = '{3'd0, 3'd7, 3'd6, 3'd4, 3'd1, 3'd5};
  logic [2:0] b_f3 [4] = '{3'd0, 3'd1, 3'd4, 3'd5};

  multicycle_core_sequencer dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .read_reg1(read_reg1),
    .read_reg2(read_reg2), .write_reg(write_reg), .alu_control(alu_control),
    .imm_val(imm_val), .sh_amt(sh_amt), .imm_val_lui(imm_val_lui), .lb(lb), .sw(sw),
    .lui_control(lui_control), .beq_control(beq_control), .bneq_control(bneq_control),
    .blt_control(blt_control), .bgeq_control(bgeq_control), .beq(beq), .bneq(bneq),
    .bge(bge), .blt(blt), .pc(pc), .halt(halt), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_b(input logic [12:0] o, input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2);
    return {o[12], o[10:5], rs2, rs1, f3, o[4:1], o[11], 7'b1100011};
  endfunction

  task automatic clear_exp();
    {e_ins, e_imm, e_lui, e_off} = '0;
    {e_alu, e_stb, e_rd, e_rs1, e_rs2, e_sh, e_fl} = '0;
    {e_wb, e_br, e_halt, e_fault, e_chk_alu, e_chk_imm, e_chk_rs2, e_chk_sh, e_chk_lui} = '0;
    e_chk_rs1 = 1;
    e_lat = 3;
  endtask

  task automatic gen(input int kind);
    logic [11:0] imm;
    logic [12:0] off;
    logic [31:0] u;
    int op;
    clear_exp();
    e_rd = 5'($urandom_range(0, 31));
    e_rs1 = 5'($urandom_range(0, 31));
    e_rs2 = 5'($urandom_range(0, 31));
    e_fl = 4'($urandom_range(0, 15));
    imm = 12'($urandom);
    e_imm = {{20{imm[11]}}, imm};
    case (kind)
      0: begin
        op = $urandom_range(0, 7);
        e_ins = {(op == 1) ? 7'h20 : 7'h00, e_rs2, e_rs1, r_f3[op], e_rd, 7'b0110011};
        e_alu = 6'(op + 1); e_chk_alu = 1; e_wb = 1; e_chk_rs2 = 1;
      end
      1: begin
        op = $urandom_range(0, 5);
        if (op >= 4) imm = 12'($urandom_range(0, 31));
        e_imm = {{20{imm[11]}}, imm};
        e_ins = {imm, e_rs1, i_f3[op], e_rd, 7'b0010011};
        e_alu = 6'(11 + op); e_chk_alu = 1; e_wb = 1; e_chk_imm = 1; e_sh = imm[3:0]; e_chk_sh = 1;
      end
      2: begin
        e_ins = {imm, e_rs1, 3'b000, e_rd, 7'b0000011};
        e_stb = 7'b1000000; e_wb = 1; e_chk_imm = 1;
      end
      3: begin
        e_ins = {imm[11:5], e_rs2, e_rs1, 3'b010, imm[4:0], 7'b0100011};
        e_stb = 7'b0100000; e_lat = 2; e_chk_imm = 1; e_chk_rs2 = 1;
      end
      4: begin
        u = $urandom;
        e_ins = {u[31:12], e_rd, 7'b0110111};
        e_lui = {u[31:12], 12'b0}; e_stb = 7'b0010000; e_wb = 1; e_chk_lui = 1; e_chk_rs1 = 0;
      end
      default: begin
        op = $urandom_range(0, 3);
        off = {12'($urandom), 1'b0};
        e_ins = enc_b(off, b_f3[op], e_rs1, e_rs2);
        e_off = {{19{off[12]}}, off}; e_imm = e_off; e_chk_imm = 1;
        e_alu = 6'(20 + op); e_chk_alu = 1; e_stb = 7'b0001000 >> op;
        e_br = 1; e_lat = 2; e_chk_rs2 = 1;
        e_fl = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'd0;
      end
    endcase
  endtask

  task automatic run(input int dly);
    logic [6:0] cur, stb_or, stb_ex;
    logic [5:0] alu1, alu_l;
    logic [31:0] imm1, lui1;
    logic [4:0] wr_val, r1, r2;
    logic [3:0] sh1;
    int n, stb_cyc, wr_cyc;
    bit done;
    {beq, bneq, bge, blt} = e_fl;
    check("fetch_req", imem_req, 1);
    check("fetch_addr", imem_addr, mpc);
    imem_ready = 0;
    repeat (dly) @(negedge clk);
    imem_ready = 1;
    imem_rdata = e_ins;
    @(negedge clk);
    imem_ready = 0;
    imem_rdata = $urandom;
    {stb_or, stb_ex, alu1, alu_l, imm1, lui1, wr_val, r1, r2, sh1} = '0;
    n = 0; stb_cyc = 0; wr_cyc = 0; done = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      if (imem_req || halt) begin
        done = 1;
        break;
      end
      n++;
      cur = {lb, sw, lui_control, beq_control, bneq_control, blt_control, bgeq_control};
      stb_or |= cur;
      if (cur != 0) stb_cyc++;
      if (k == 2) stb_ex = cur;
      if (write_reg != 0) begin
        wr_cyc++;
        wr_val = write_reg;
      end
      if (k == 1) begin
        alu1 = alu_control; imm1 = imm_val; lui1 = imm_val_lui;
        r1 = read_reg1; r2 = read_reg2; sh1 = sh_amt;
      end
      alu_l = alu_control;
    end
    check("instr_done", done, 1);
    if (e_halt) begin
      check("halt", halt, 1);
      check("halt_fault", fault, e_fault);
      check("halt_req", imem_req, 0);
      check("halt_lat", n, 1);
      check("halt_strobes", stb_or, 0);
      return;
    end
    check("latency", n, e_lat);
    check("strobe_exec", stb_ex, e_stb);
    check("strobe_cycles", stb_cyc, e_stb != 0);
    check("wr_cycles", wr_cyc, e_wb && e_rd != 0);
    if (e_wb && e_rd != 0) check("wr_reg", wr_val, e_rd);
    if (e_chk_alu) check("alu_decode", alu1, e_alu);
    if (e_chk_alu) check("alu_hold", alu_l, e_alu);
    if (e_chk_imm) check("imm_val", imm1, e_imm);
    if (e_chk_lui) check("imm_lui", lui1, e_lui);
    if (e_chk_sh) check("sh_amt", sh1, e_sh);
    if (e_chk_rs1) check("rs1", r1, e_rs1);
    if (e_chk_rs2) check("rs2", r2, e_rs2);
    mpc = (e_br && e_fl != 0) ? mpc + e_off : mpc + 32'd4;
  endtask

  task automatic do_reset();
    imem_ready = 0;
    {beq, bneq, bge, blt} = 4'd0;
    rst = 0;
    #1;
    check("rst_halt", halt, 0);
    check("rst_fault", fault, 0);
    check("rst_pc", pc, 32'h0);
    check("rst_wr", write_reg, 0);
    check("rst_alu", alu_control, 0);
    check("rst_strobes", {lb, sw, lui_control, beq_control, bneq_control, blt_control, bgeq_control}, 0);
    @(negedge clk);
    rst = 1;
    mpc = 32'h0;
    @(negedge clk);
    check("post_rst_req", imem_req, 1);
    check("post_rst_addr", imem_addr, 32'h0);
  endtask

  initial begin
    int n;
    #2;
    do_reset();
    clear_exp();
    e_ins = 32'h00500093; e_alu = 6'd11; e_chk_alu = 1; e_imm = 32'd5; e_chk_imm = 1;
    e_rd = 5'd1; e_wb = 1; e_sh = 4'd5; e_chk_sh = 1;
    run(0);
    clear_exp();
    e_ins = 32'h00000463; e_br = 1; e_off = 32'd8; e_imm = 32'd8; e_chk_imm = 1;
    e_alu = 6'd20; e_chk_alu = 1; e_stb = 7'b0001000; e_lat = 2; e_chk_rs2 = 1; e_fl = 4'b1000;
    run(1);
    e_fl = 4'b0000;
    run(2);
    gen(3); run(0);
    gen(2); run(3);
    gen(1); run(7);
    gen(5); e_fl = 4'b1111; run(0);
    repeat (80) begin
      gen($urandom_range(0, 5));
      run($urandom_range(0, 6));
    end
    imem_ready = 0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n++;
      if (halt) break;
    end
    check("timeout_cycles", n, 8);
    check("timeout_fault", fault, 1);
    check("timeout_req", imem_req, 0);
    check("timeout_pc", pc, mpc);
    repeat (3) @(negedge clk);
    check("halt_sticky", halt, 1);
    check("halt_pc_frozen", pc, mpc);
    do_reset();
    clear_exp();
    e_ins = enc_b(13'h1FFC, 3'd0, 5'd0, 5'd0); e_off = 32'hFFFF_FFFC; e_imm = e_off; e_chk_imm = 1;
    e_alu = 6'd20; e_chk_alu = 1; e_stb = 7'b0001000; e_br = 1; e_lat = 2; e_chk_rs2 = 1; e_fl = 4'b1000;
    run(0);
    check("wrap_top", pc, 32'hFFFF_FFFC);
    gen(2); run(0);
    check("wrap_zero", imem_addr, 32'h0);
    clear_exp();
    e_ins = 32'hFFFF_FFFF; e_halt = 1; e_fault = 1;
    run(0);
    do_reset();
    clear_exp();
    e_ins = 32'h0000_0073; e_halt = 1; e_fault = 0;
    run(0);
    check("ecall_pc", pc, mpc);
    do_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/multicycle_core_sequencer.md
Name: multicycle_core_sequencer

Overview:
- Multi-cycle control FSM that fetches RV32I-subset instructions from instruction memory, decodes them and drives every control/select input of the existing datapath (register-file read/write selects, ALU opcode, immediates, load/store/LUI strobes, branch enables).
- Owns the PC and closes the loop on the datapath's beq/bneq/bge/blt outcome flags to select the next PC.
- Sits between the instruction memory and the datapath in the top-level processor.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_TIMEOUT, 8, max cycles waiting for imem_ready before entering HALT with fault.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request, held until accepted
- imem_addr  out  32  fetch address (PC)
- imem_ready  in  1  instruction valid on imem_rdata this cycle
- imem_rdata  in  32  fetched instruction
- read_reg1, read_reg2  out  5 each  rs1/rs2 selects
- write_reg  out  5  rd select; 0 except in WRITEBACK
- alu_control  out  6  ALU opcode
- imm_val  out  32  sign-extended I/S/B immediate
- sh_amt  out  4  instr[23:20]
- imm_val_lui  out  32  {instr[31:12],12'b0}
- lb, sw, lui_control  out  1 each  load/store/LUI strobes
- beq_control, bneq_control, blt_control, bgeq_control  out  1 each  branch enables
- beq, bneq, bge, blt  in  1 each  datapath branch-taken flags
- pc  out  32  current PC
- halt  out  1  core stopped
- fault  out  1  illegal opcode or fetch timeout

Behaviour:
- Reset (rst=0, asynchronous): state=FETCH, pc=RESET_PC, instruction register=32'h0000_0013 (NOP), all strobes/enables=0, write_reg=0, alu_control=0, halt=0, fault=0, timeout counter=0. Releasing reset mid-fetch restarts the fetch from RESET_PC.
- States: FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH; HALT is terminal until reset.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ready=1: latch imem_rdata into IR, drop imem_req next cycle, go to DECODE.
  - Timeout counter increments each waiting cycle; when it reaches IMEM_TIMEOUT, go to HALT with fault=1.
- DECODE (1 cycle): register read selects, immediates and alu_control are driven from IR. They are held stable through EXECUTE and WRITEBACK.
- Opcode map (IR[6:0]):
  - 0110011 R-type: funct3/funct7 select ADD=1, SUB=2, AND=3, OR=4, XOR=5, SLL=6, SRL=7, SLT=8.
  - 0010011 I-ALU: ADDI=11, ANDI=12, ORI=13, XORI=14, SLLI=15, SRLI=16.
  - 0000011 LB: lb=1.
  - 0100011 SW: sw=1.
  - 0110111 LUI: lui_control=1.
  - 1100011 branch: funct3 000->beq_control (alu 20), 001->bneq_control (21), 100->blt_control (22), 101->bgeq_control (23).
  - 1110011 ECALL/EBREAK: HALT, fault=0.
  - Any other opcode: HALT, fault=1.
- EXECUTE (1 cycle):
  - Branch enables and lb/sw/lui_control are asserted in this cycle only (single-cycle pulses).
  - Branches: sample the flags at the end of EXECUTE. If any flag is 1, next_pc = pc + B-immediate (32-bit wraparound); else next_pc = pc+4.
  - Branches skip WRITEBACK and go straight to FETCH.
  - SW: sw pulse only, no WRITEBACK.
- WRITEBACK (1 cycle): write_reg=rd. write_reg is 0 in all other states, so no unintended RF write. pc <= pc+4, wrapping at 32'hFFFF_FFFC -> 0.
- Latency:
  - Non-branch: 4 cycles + fetch wait.
  - Branch and SW: 3 cycles + fetch wait.
- HALT: halt=1, all strobes/enables 0, imem_req=0, pc frozen. Only reset exits.
- Simultaneous events:
  - imem_ready on the same cycle as the timeout terminal count: the fetch is accepted.
  - More than one branch flag high: treated as taken.

Test Plan:
- Reset with RESET_PC=0, imem_ready tied 1 -> imem_req=1, imem_addr=0 one cycle after rst release; all strobes 0 during reset.
- ADDI x1,x0,5 (32'h00500093) -> alu_control=11, imm_val=5; write_reg=1 only in WRITEBACK; next fetch at pc=4.
- BEQ x0,x0,+8 with datapath beq=1 in EXECUTE -> beq_control pulses 1 cycle, next imem_addr=pc+8. Same instruction with beq=0 -> pc+4.
- SW then LB -> sw pulse 1 cycle with write_reg=0 throughout. LB: lb pulse, write_reg=rd in WRITEBACK.
- imem_ready held 0 for 8 cycles -> halt=1, fault=1, imem_req=0. Pulse rst low mid-HALT -> back to FETCH at RESET_PC.
- Illegal opcode 32'hFFFFFFFF -> HALT, fault=1. ECALL (32'h00000073) -> HALT, fault=0.
